// File: rtl/regs8_serializer.sv
// Parallel-in, serial-out reader for 8-bit register words: one byte per load
// handshake, shifted out on sdo inside a frame window. Optional even-parity bit
// is enabled by defining REGS8_SER_PARITY_EN.
module regs8_serializer #(
   parameter int MSB_FIRST  = 1,
   parameter int BIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic [7:0] D,
   input  logic       load,
   output logic       in_ready,
   output logic       sdo,
   output logic       frame,
   output logic       done
);

`ifdef REGS8_SER_PARITY_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 3;
`endif

   localparam logic [7:0]       HOLD_RELOAD = 8'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(7);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_e;

   state_e           state_q,   state_d;
   logic [7:0]       shreg_q,   shreg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]       hold_q,    hold_d;
   logic             done_q,    done_d;
   logic             head_bit;
   logic [7:0]       shreg_next;

`ifdef REGS8_SER_PARITY_EN
   logic parity_q, parity_d;
`endif

   // Head is the bit currently on the wire; the register always shifts toward it.
   always_comb begin
      head_bit   = 1'b0;
      shreg_next = 8'h00;
      if (MSB_FIRST != 0) begin
         head_bit   = shreg_q[7];
         shreg_next = {shreg_q[6:0], 1'b0};
      end else begin
         head_bit   = shreg_q[0];
         shreg_next = {1'b0, shreg_q[7:1]};
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      hold_d    = hold_q;
      done_d    = 1'b0;
`ifdef REGS8_SER_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d   = ST_SHIFT;
               shreg_d   = D;
               bit_cnt_d = '0;
               hold_d    = HOLD_RELOAD;
`ifdef REGS8_SER_PARITY_EN
               parity_d  = ^D;
`endif
            end
         end
         ST_SHIFT: begin
            if (hold_q != 8'd0) begin
               hold_d = hold_q - 8'd1;
            end else if (bit_cnt_q == LAST_BIT) begin
`ifdef REGS8_SER_PARITY_EN
               state_d   = ST_PARITY;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               hold_d    = HOLD_RELOAD;
`else
               state_d   = ST_IDLE;
               done_d    = 1'b1;
`endif
            end else begin
               shreg_d   = shreg_next;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               hold_d    = HOLD_RELOAD;
            end
         end
`ifdef REGS8_SER_PARITY_EN
         ST_PARITY: begin
            if (hold_q != 8'd0) begin
               hold_d = hold_q - 8'd1;
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= ST_IDLE;
         shreg_q   <= 8'h00;
         bit_cnt_q <= '0;
         hold_q    <= 8'd0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
      end
   end

`ifdef REGS8_SER_PARITY_EN
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   // All outputs decode flops only; load and D never reach them combinationally.
   always_comb begin
      in_ready = (state_q == ST_IDLE);
      frame    = (state_q != ST_IDLE);
      done     = done_q;
      case (state_q)
         ST_SHIFT:  sdo = head_bit;
`ifdef REGS8_SER_PARITY_EN
         ST_PARITY: sdo = parity_q;
`endif
         default:   sdo = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_regs8_serializer.sv
// Directed bench for regs8_serializer: three instances cover MSB/LSB order and
// multi-cycle bit hold; expected sdo bits are queued at load and popped per cycle.
module tb_regs8_serializer;

   logic       clk;
   logic       clear_n;
   logic       load     [3];
   logic [7:0] d        [3];
   logic       in_ready [3];
   logic       sdo      [3];
   logic       frame    [3];
   logic       done     [3];

   logic [0:0] exp_q[$];
   int         pass_cnt;
   int         tot_cnt;

   regs8_serializer #(.MSB_FIRST(1), .BIT_CYCLES(1)) u_msb (
      .clk(clk), .clear_n(clear_n), .D(d[0]), .load(load[0]),
      .in_ready(in_ready[0]), .sdo(sdo[0]), .frame(frame[0]), .done(done[0])
   );

   regs8_serializer #(.MSB_FIRST(0), .BIT_CYCLES(1)) u_lsb (
      .clk(clk), .clear_n(clear_n), .D(d[1]), .load(load[1]),
      .in_ready(in_ready[1]), .sdo(sdo[1]), .frame(frame[1]), .done(done[1])
   );

   regs8_serializer #(.MSB_FIRST(1), .BIT_CYCLES(3)) u_bc3 (
      .clk(clk), .clear_n(clear_n), .D(d[2]), .load(load[2]),
      .in_ready(in_ready[2]), .sdo(sdo[2]), .frame(frame[2]), .done(done[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Queue the bit sequence a frame of word w must produce, one entry per cycle.
   task automatic start(input int u, input logic [7:0] w, input bit msb, input int bc);
      logic b;
      load[u] = 1'b1;
      d[u]    = w;
      for (int i = 0; i < 8; i++) begin
         b = msb ? w[7-i] : w[i];
         for (int k = 0; k < bc; k++) exp_q.push_back(b);
      end
`ifdef REGS8_SER_PARITY_EN
      for (int k = 0; k < bc; k++) exp_q.push_back(^w);
`endif
   endtask

   // One clock: data cycle while bits remain queued, otherwise the done cycle.
   task automatic cycle(input int u);
      logic [0:0] e;
      @(negedge clk);
      load[u] = 1'b0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("sdo[u%0d]", u), {7'd0, sdo[u]}, {7'd0, e});
         check($sformatf("frame[u%0d]", u), {7'd0, frame[u]}, 8'd1);
         check($sformatf("busy_in_ready[u%0d]", u), {7'd0, in_ready[u]}, 8'd0);
         check($sformatf("busy_done[u%0d]", u), {7'd0, done[u]}, 8'd0);
      end else begin
         check($sformatf("done[u%0d]", u), {7'd0, done[u]}, 8'd1);
         check($sformatf("done_sdo[u%0d]", u), {7'd0, sdo[u]}, 8'd1);
         check($sformatf("done_frame[u%0d]", u), {7'd0, frame[u]}, 8'd0);
         check($sformatf("done_in_ready[u%0d]", u), {7'd0, in_ready[u]}, 8'd1);
      end
   endtask

   task automatic finish_frame(input int u);
      while (exp_q.size() > 0) cycle(u);
      cycle(u);
   endtask

   task automatic idle_check(input string tag, input int u);
      check({tag, "_sdo"}, {7'd0, sdo[u]}, 8'd1);
      check({tag, "_frame"}, {7'd0, frame[u]}, 8'd0);
      check({tag, "_in_ready"}, {7'd0, in_ready[u]}, 8'd1);
      check({tag, "_done"}, {7'd0, done[u]}, 8'd0);
   endtask

   initial begin
      pass_cnt = 0;
      tot_cnt  = 0;
      clear_n  = 1'b0;
      for (int u = 0; u < 3; u++) begin
         load[u] = 1'b0;
         d[u]    = 8'h00;
      end
      #1;
      for (int u = 0; u < 3; u++) idle_check($sformatf("reset_u%0d", u), u);
      repeat (2) @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 3; u++) idle_check($sformatf("post_reset_u%0d", u), u);

      // MSB first, one cycle per bit.
      start(0, 8'hA5, 1'b1, 1);
      finish_frame(0);
      @(negedge clk);
      idle_check("after_a5", 0);

      // LSB first.
      start(1, 8'h01, 1'b0, 1);
      finish_frame(1);

      // Three cycles per bit: 24-cycle frame.
      start(2, 8'hF0, 1'b1, 3);
      finish_frame(2);

      // Loads during a frame are ignored; load in the done cycle is accepted.
      start(0, 8'h3C, 1'b1, 1);
      cycle(0);
      cycle(0);
      load[0] = 1'b1;
      d[0]    = 8'hFF;
      cycle(0);
      cycle(0);
      cycle(0);
      load[0] = 1'b1;
      d[0]    = 8'hFF;
      finish_frame(0);
      start(0, 8'h81, 1'b1, 1);
      d[0] = 8'h81;
      finish_frame(0);
      @(negedge clk);
      idle_check("after_81", 0);

      // Asynchronous clear mid-frame aborts with no done pulse.
      start(0, 8'hAA, 1'b1, 1);
      cycle(0);
      cycle(0);
      cycle(0);
      cycle(0);
      #2;
      clear_n = 1'b0;
      #1;
      idle_check("abort", 0);
      exp_q.delete();
      @(negedge clk);
      idle_check("abort_held", 0);
      clear_n = 1'b1;
      @(negedge clk);
      idle_check("abort_release", 0);
      start(0, 8'h55, 1'b1, 1);
      finish_frame(0);

`ifdef REGS8_SER_PARITY_EN
      start(0, 8'h07, 1'b1, 1);
      finish_frame(0);
      start(1, 8'h03, 1'b0, 1);
      finish_frame(1);
      start(2, 8'h03, 1'b1, 3);
      finish_frame(2);
`endif

      @(negedge clk);
      for (int u = 0; u < 3; u++) idle_check($sformatf("final_u%0d", u), u);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
